// File: rtl/shift_ctrl.sv
// shift_ctrl: load/shift sequencer for the downstream 4-bit register stage.
// Accepts words with a shift count into a one-entry buffer, then issues one
// load strobe, the requested number of shift strobes and a done pulse.
module shift_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CNT_W-1:0] in_len,
    output logic [WIDTH-1:0] d_load,
    output logic             load_en,
    output logic             shift_en,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             buf_full;
    logic [WIDTH-1:0] buf_data;
    logic [CNT_W-1:0] buf_len;
    logic [CNT_W-1:0] cnt;
    logic             push;
    logic             pop;

    assign in_ready = ~buf_full;
    assign push     = in_valid & ~buf_full;
    // Pop only between words; push needs an empty buffer so the two never coincide
    assign pop      = buf_full & ((state == IDLE) | (state == DONE));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and strobe decode from the registered state
    always_comb begin
        state_nxt = state;
        load_en   = 1'b0;
        shift_en  = 1'b0;
        done      = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (buf_full) state_nxt = LOAD;
            end
            LOAD: begin
                load_en = 1'b1;
                if (cnt == '0) state_nxt = DONE;
                else           state_nxt = SHIFT;
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (cnt <= CNT_W'(1)) state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (buf_full) state_nxt = LOAD;
                else          state_nxt = IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // One-entry input buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_full <= 1'b0;
            buf_data <= '0;
            buf_len  <= '0;
        end else if (push) begin
            buf_full <= 1'b1;
            buf_data <= in_data;
            buf_len  <= in_len;
        end else if (pop) begin
            buf_full <= 1'b0;
        end
    end

    // Load word register and shift counter; counter saturates at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_load <= '0;
            cnt    <= '0;
        end else if (pop) begin
            d_load <= buf_data;
            cnt    <= buf_len;
        end else if ((state == SHIFT) && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: doc/shift_ctrl.md
# shift_ctrl

Sequencer that sits directly upstream of the 4-bit load/shift register stage and generates its `d_load`, `load_en` and `shift_en` controls. Words arrive on a valid/ready handshake with a per-word shift count and are held in a one-entry buffer. For each word the block issues one load pulse, then exactly the requested number of shift pulses, then a one-cycle `done` pulse. Back-to-back words are sequenced without returning to idle.

## Interface
Parameters:
- `WIDTH`, 4: data width of the loaded word; matches the downstream register width.
- `CNT_W`, 4: width of the shift count; maximum shift count is 2^CNT_W-1.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset. Asynchronous, active-low. Asserting it clears all state immediately.
- `in_valid`  in  1  upstream word present.
- `in_ready`  out  1  buffer empty, word can be accepted.
- `in_data`  in  WIDTH  word to load.
- `in_len`  in  CNT_W  number of shift pulses for this word; sampled together with `in_data`.
- `d_load`  out  WIDTH  load data to the downstream register; registered.
- `load_en`  out  1  one-cycle load strobe.
- `shift_en`  out  1  shift strobe, held high for `in_len` consecutive cycles.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the last shift of a word.

## Operation
- Buffer:
  - `buf_full` flag plus `buf_data` and `buf_len` registers.
  - `in_ready = ~buf_full`, combinational from the flag only.
  - Push on `in_valid & in_ready`.
  - Pop only when FSM is in IDLE or DONE and `buf_full=1`.
  - Push requires an empty buffer and pop requires a full one, so they never occur in the same cycle.
- FSM states: IDLE, LOAD, SHIFT, DONE.
  - IDLE: if `buf_full`, pop into `d_load` and `cnt`, then go to LOAD. Otherwise stay.
  - LOAD: `load_en=1` for exactly one cycle.
    - If `cnt==0`, go to DONE.
    - Otherwise go to SHIFT.
  - SHIFT: `shift_en=1` every cycle, and `cnt` decrements each cycle.
    - If `cnt==1`, go to DONE.
    - Otherwise stay in SHIFT.
  - DONE: `done=1` for one cycle.
    - If `buf_full`, pop and go to LOAD, skipping IDLE.
    - Otherwise go to IDLE.
- Output values:
  - `d_load` holds the popped word from the LOAD cycle until the next pop.
  - `load_en`, `shift_en`, `done` and `busy` are decoded from the registered state.
  - `load_en`, `shift_en` and `done` are mutually exclusive.
- `cnt` is CNT_W bits wide. It never decrements below 0 and never wraps.
- `in_len=0` produces a load followed directly by `done`, with no shift pulses.
- Reset, including mid-operation: state returns to IDLE and `buf_full=0`. All outputs are 0 except `in_ready=1`.
  - `d_load`, `buf_data`, `buf_len` and `cnt` reset to 0.
  - A word in flight or in the buffer is discarded without a `done`.
- `in_data` and `in_len` are ignored while `in_ready=0`.

## Timing
- Cycle numbering: push accepted on edge E0.
  - Cycle after E0: IDLE with `buf_full=1`.
  - Next cycle: LOAD, with `load_en=1` and valid `d_load`. Word-to-load latency is 2 cycles.
- SHIFT occupies the next L cycles, then DONE occupies 1 cycle.
- A word occupies the FSM for L+2 cycles (LOAD + L SHIFT + DONE).
  - With a buffered successor, the next LOAD follows DONE immediately.
  - Sustained throughput is one word per L+2 cycles, provided upstream refills the buffer within that window.
- `in_ready` rises the cycle after a pop, so the next push can be accepted during LOAD.
- `busy` rises with LOAD. It falls the cycle after DONE only if no successor is buffered.

## Test plan
- Reset then idle: hold `rst_n=0` 2 cycles, release, keep `in_valid=0` for 10 cycles.
  - All outputs stay 0 and `in_ready` stays 1.
- Single word: push `in_data=4'hA`, `in_len=3`.
  - 2 cycles later, `load_en=1` with `d_load=4'hA`.
  - Then `shift_en=1` for exactly 3 cycles, then `done=1` for 1 cycle, then IDLE.
- Zero length: push `4'h5`, `in_len=0`.
  - LOAD cycle is followed immediately by `done`, with no `shift_en`.
- Back-to-back: push `4'h3`/len 2, then push `4'hC`/len 1 during the first word's LOAD.
  - Sequence: LOAD(3), SH, SH, DONE, LOAD(C), SH, DONE.
  - `busy` stays high throughout, and `in_ready=0` while the second word is buffered.
- Reset mid-shift: push `4'hF`/len 15, assert `rst_n=0` asynchronously during the 5th shift cycle.
  - `shift_en` and `busy` drop without waiting for a clock edge.
  - No `done` is issued, and after release the block is idle with `in_ready=1`.
- Max length: `in_len=4'hF`.
  - Exactly 15 `shift_en` cycles, with no counter wrap.
